// File: rtl/wb_regfile_stage_pkg.sv
// Shared decode constants, FSM state type and long-op classifier for the
// write-back stage.
package wb_pkg;

    localparam logic [3:0] OP_ALU  = 4'h0;
    localparam logic [3:0] OP_ADDI = 4'h1;
    localparam logic [3:0] OP_LW   = 4'h8;
    localparam logic [3:0] OP_SW   = 4'hB;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [3:0] F_MUL = 4'h4;
    localparam logic [3:0] F_DIV = 4'h5;

    typedef enum logic {
        S_WRITE,
        S_HI
    } wb_state_t;

    // MUL/DIV produce a 32-bit result that needs a second write-port cycle.
    function automatic logic is_long_op(input logic [15:0] instr);
        return (instr[15:12] == OP_ALU) &&
               ((instr[3:0] == F_MUL) || (instr[3:0] == F_DIV));
    endfunction

endpackage

// File: rtl/wb_regfile_stage_if.sv
// MEM/WB-side inputs, ID read ports, forwarding and hazard outputs of the
// write-back stage bundled as one interface.
interface wb_regfile_stage_if #(
    parameter int DW = 16,
    parameter int AW = 4
);

    logic            valid_in;
    logic [15:0]     instruction_in;
    logic [DW-1:0]   read_data_in;
    logic [2*DW-1:0] alu_result_in;
    logic [AW-1:0]   rs_addr;
    logic [AW-1:0]   rt_addr;
    logic [DW-1:0]   rs_data;
    logic [DW-1:0]   rt_data;
    logic            wb_fwd_valid;
    logic [AW-1:0]   wb_fwd_addr;
    logic [DW-1:0]   wb_fwd_data;
    logic            stall_out;
    logic [31:0]     retired_cnt;

    modport master (
        output valid_in, instruction_in, read_data_in, alu_result_in,
        output rs_addr, rt_addr,
        input  rs_data, rt_data,
        input  wb_fwd_valid, wb_fwd_addr, wb_fwd_data,
        input  stall_out, retired_cnt
    );

    modport slave (
        input  valid_in, instruction_in, read_data_in, alu_result_in,
        input  rs_addr, rt_addr,
        output rs_data, rt_data,
        output wb_fwd_valid, wb_fwd_addr, wb_fwd_data,
        output stall_out, retired_cnt
    );

endinterface

// File: rtl/wb_regfile_stage_regfile.sv
// Register file: one write port, two combinational write-through read ports,
// R0 hardwired to zero.
module wb_regfile #(
    parameter int DW   = 16,
    parameter int NREG = 16,
    parameter int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] ra_addr,
    output logic [DW-1:0] ra_data,
    input  logic [AW-1:0] rb_addr,
    output logic [DW-1:0] rb_data
);

    logic [DW-1:0] mem [NREG];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        ra_data = mem[ra_addr];
        if (ra_addr == '0) begin
            ra_data = '0;
        end else if (we && (ra_addr == waddr)) begin
            ra_data = wdata;
        end
    end

    always_comb begin
        rb_data = mem[rb_addr];
        if (rb_addr == '0) begin
            rb_data = '0;
        end else if (we && (rb_addr == waddr)) begin
            rb_data = wdata;
        end
    end

endmodule

// File: rtl/wb_regfile_stage.sv
// Write-back stage: decodes MEM/WB, commits to the register file, splits
// 32-bit MUL/DIV results over two cycles. Optional macro: WB_RETIRE_CNT_EN.
module wb_regfile_stage
    import wb_pkg::*;
#(
    parameter int DW     = 16,
    parameter int RW     = 32,
    parameter int NREG   = 16,
    parameter int HI_REG = 15
) (
    input  logic               clk,
    input  logic               rst,
    wb_regfile_stage_if.slave  bus
);

    localparam int AW = $clog2(NREG);
    localparam logic [AW-1:0] HI_ADDR = AW'(HI_REG);

    wb_state_t     state_q;
    wb_state_t     state_d;
    logic [DW-1:0] hi_q;
    logic          stall;
    logic          accept;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;

    logic [3:0]    op;
    logic [AW-1:0] rd;
    logic          unused_funct_gap;

    assign op = bus.instruction_in[15:12];
    assign rd = bus.instruction_in[8 +: AW];
    assign unused_funct_gap = ^bus.instruction_in[7:4];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_WRITE;
            hi_q    <= '0;
        end else begin
            state_q <= state_d;
            if (stall) begin
                hi_q <= bus.alu_result_in[RW-1:DW];
            end
        end
    end

    // Everything is gated by rst so the forward/stall outputs read 0 in reset.
    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        accept  = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        if (rst) begin
            unique case (state_q)
                S_WRITE: begin
                    if (bus.valid_in) begin
                        accept = 1'b1;
                        case (op)
                            OP_ALU, OP_ADDI: begin
                                wr_en   = 1'b1;
                                wr_addr = rd;
                                wr_data = bus.alu_result_in[DW-1:0];
                            end
                            OP_LW: begin
                                wr_en   = 1'b1;
                                wr_addr = rd;
                                wr_data = bus.read_data_in;
                            end
                            OP_SW, OP_JMP, OP_HALT: ;
                            default: ;
                        endcase
                        if (is_long_op(bus.instruction_in)) begin
                            stall   = 1'b1;
                            state_d = S_HI;
                        end
                    end
                end
                S_HI: begin
                    wr_en   = 1'b1;
                    wr_addr = HI_ADDR;
                    wr_data = hi_q;
                    state_d = S_WRITE;
                end
                default: state_d = S_WRITE;
            endcase
            if (wr_addr == '0) begin
                wr_en = 1'b0;
            end
        end
    end

    wb_regfile #(
        .DW   (DW),
        .NREG (NREG),
        .AW   (AW)
    ) u_rf (
        .clk     (clk),
        .rst     (rst),
        .we      (wr_en),
        .waddr   (wr_addr),
        .wdata   (wr_data),
        .ra_addr (bus.rs_addr),
        .ra_data (bus.rs_data),
        .rb_addr (bus.rt_addr),
        .rb_data (bus.rt_data)
    );

    assign bus.stall_out    = stall;
    assign bus.wb_fwd_valid = wr_en;
    assign bus.wb_fwd_addr  = wr_en ? wr_addr : '0;
    assign bus.wb_fwd_data  = wr_en ? wr_data : '0;

`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retired_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retired_q <= '0;
        end else if (accept) begin
            retired_q <= retired_q + 32'd1;
        end
    end

    assign bus.retired_cnt = retired_q;
`else
    logic unused_accept;

    assign unused_accept   = accept;
    assign bus.retired_cnt = '0;
`endif

endmodule

// File: doc/wb_regfile_stage.md
Name: wb_regfile_stage

Overview:
- Write-back end of the MEM/WB interface: consumes the instruction, load data and 32-bit ALU result presented by the MEM/WB pipeline register.
- Commits results into the 16 x 16-bit register file.
- Serves the two ID-stage read ports and publishes the write-in-progress for the forwarding unit.
- Has a single write port, so 32-bit results (MUL/DIV) take two cycles; the block stalls the front of the pipe for that second cycle.

Parameters:
- DW, 16, register/data width
- RW, 32, ALU result width (always 2*DW)
- NREG, 16, number of registers (address width 4)
- HI_REG, 15, destination of the upper half of 32-bit results

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- valid_in  in  1  MEM/WB holds a real instruction (0 = bubble)
- instruction_in  in  16  [15:12] opcode, [11:8] rd, [3:0] funct
- read_data_in  in  16  load data from data memory
- alu_result_in  in  32  ALU result; [15:0] low, [31:16] high
- rs_addr, rt_addr  in  4 each  ID-stage read addresses
- rs_data, rt_data  out  16 each  ID-stage read data
- wb_fwd_valid  out  1  a register write occurs this cycle
- wb_fwd_addr  out  4  register being written
- wb_fwd_data  out  16  value being written
- stall_out  out  1  hazard unit must hold IF..EX/MEM and load a bubble into MEM/WB
- retired_cnt  out  32  instructions retired (see Optional Feature)

Behaviour:
- Reset (rst=0, async): all registers 0, state S_WRITE, hi latch 0, retired_cnt 0.
  - Outputs during reset: stall_out 0, wb_fwd_valid 0, wb_fwd_data 0, wb_fwd_addr 0.
- Instruction classes (decoded in S_WRITE only, when valid_in=1):
  - OP_ALU with funct MUL or DIV: long op. rd <= alu[15:0], HI_REG <= alu[31:16] one cycle later (DIV: quotient low, remainder high).
  - Other OP_ALU and OP_ADDI: rd <= alu[15:0].
  - OP_LW: rd <= read_data_in.
  - OP_SW, branches, OP_JMP, OP_HALT, NOP, and valid_in=0: no write.
- R0 reads 0 always; writes to R0 are dropped, and wb_fwd_valid is 0 for them.
- Write happens at the rising edge closing the WB cycle.
- Read ports are combinational with write-through: if the read address equals wb_fwd_addr and wb_fwd_valid=1, return wb_fwd_data, else the stored value.
- Forward outputs are combinational, valid in the same cycle as the write.
- FSM:
  - S_WRITE: perform the write above. On a long op, latch alu[31:16], assert stall_out=1 (combinational, this cycle only), and go to S_HI.
  - S_HI: write the latch into HI_REG (wb_fwd_* show HI_REG and the latch), stall_out=0, ignore all inputs, return to S_WRITE.
- Contract: during S_HI, MEM/WB carries a bubble. A valid_in=1 arriving in S_HI is dropped (no write, not counted).
- A long op with rd=HI_REG: low half written first, then overwritten by the high half.
- Back-to-back long ops are impossible by contract; if presented, each is processed as S_WRITE->S_HI in sequence.
- Reset asserted in S_HI: the pending high write is discarded.

Optional Feature:
- Macro WB_RETIRE_CNT_EN.
- Defined: retired_cnt increments by 1 (wrapping at 2^32) on every valid_in=1 instruction accepted in S_WRITE, including non-writing ones. A long op counts once.
- Undefined: retired_cnt is constant 0 and no counter flops exist.

Decomposition:
- Package wb_pkg:
  - opcode constants OP_ALU=4'h0, OP_ADDI=4'h1, OP_LW=4'h8, OP_SW=4'hB, OP_JMP=4'hC, OP_HALT=4'hF
  - funct constants F_MUL=4'h4, F_DIV=4'h5
  - wb_state_t enum {S_WRITE, S_HI}
  - function is_long_op
- Sub-module wb_regfile: 16x16 storage, one write port, two write-through read ports, R0 hardwired.
- FSM and decode live in the top module.

Test Plan:
- Reset then read all 16 addresses -> all 0; stall_out=0, wb_fwd_valid=0.
- ALU add, rd=3, alu=32'h0000_1234 -> R3=16'h1234 next edge; rs_addr=3 the same cycle -> rs_data=16'h1234 (write-through).
- LW rd=5, read_data_in=16'hBEEF, alu=32'h0000_0040 -> R5=16'hBEEF; alu ignored.
- MUL rd=2, alu=32'hABCD_0123:
  - cycle N: stall_out=1, fwd (2,16'h0123)
  - cycle N+1: fwd (15,16'hABCD), stall_out=0
  - result: R2=16'h0123, R15=16'hABCD.
- ALU write rd=0 with alu=16'hFFFF -> R0 still reads 0, wb_fwd_valid=0; SW and bubble -> no register changes.
- rst low during S_HI of MUL rd=4 -> R15 unchanged (0), state S_WRITE. With WB_RETIRE_CNT_EN: 3 instructions + 1 bubble -> retired_cnt=3.
